cfg_chain_ctrl: RTL and testbench

Byte-command controller that sequences loading of the configuration shift chain from the host UART link. It sits between the UART byte interface and the chain's head, tail and enable pins. It accepts LOAD, STATUS and STEP commands and returns reply bytes through the UART transmit handshake. It also issues single-cycle user-clock step pulses to the configured logic.

---
 rtl/cfg_chain_ctrl.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cfg_chain_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_ctrl.sv
// ---------------------------------------------------------------------------
// cfg_chain_ctrl
// Byte-command controller that loads the configuration shift chain from the
// host UART link, answers STATUS queries and issues single-cycle user-clock
// step pulses.
//
// Commands (accepted in IDLE only):
//   0x01 LOAD   : NBYTES payload bytes follow, each shifted LSB first
//   0x02 STATUS : reply {OVR, TMO, load_count[5:0]}, then clear OVR/TMO
//   0x03 STEP   : one-cycle USER_STEP pulse, no reply
//   other       : reply 0xEE
//
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   IN_VALID, IN_DATA     received UART byte strobe and data
//   UART_READY            transmitter can accept a byte
//   OUT_VALID, OUT_DATA   reply byte strobe and data (data holds)
//   SHIFT_HEAD/TAIL       serial data into / out of the chain
//   SHIFT_ENABLE          chain shift enable
//   USER_STEP             one-cycle user clock step
//   BUSY                  controller not in IDLE
//
// Build option: define CFG_CHAIN_READBACK_EN to reply with the 8 bits shifted
// out of the tail after every payload byte instead of one final 0xAC.
// ---------------------------------------------------------------------------
module cfg_chain_ctrl #(
  parameter int CHAIN_LEN = 40,
  parameter int TIMEOUT   = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       IN_VALID,
  input  logic [7:0] IN_DATA,
  input  logic       UART_READY,
  output logic       OUT_VALID,
  output logic [7:0] OUT_DATA,
  output logic       SHIFT_HEAD,
  input  logic       SHIFT_TAIL,
  output logic       SHIFT_ENABLE,
  output logic       USER_STEP,
  output logic       BUSY
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  TMO_MAX   = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_REPLY     = 2'd3
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [BCW-1:0] byte_cnt_r;
  logic [2:0]     bit_cnt_r;
  logic [TW-1:0]  tmo_cnt_r;
  logic [5:0]     load_cnt_r;
  logic           ovr_r, tmo_r;
  logic [7:0]     data_r;
  logic [7:0]     reply_data_r;
  logic           sel_status_r;   // reply is the live status byte
  logic           ret_idle_r;     // REPLY returns to IDLE (else LOAD_WAIT)
  logic           tmo_hit_s, last_byte_s, bit_last_s, tx_s;

  logic           out_valid_nxt_s, shift_head_nxt_s, shift_enable_nxt_s;
  logic           user_step_nxt_s, busy_nxt_s;
  logic [7:0]     out_data_nxt_s;

`ifdef CFG_CHAIN_READBACK_EN
  logic [7:0]     readback_r;
`else
  logic           unused_tail_s;
  assign unused_tail_s = SHIFT_TAIL;
`endif

  assign tmo_hit_s   = (state_r == ST_LOAD_WAIT) && (tmo_cnt_r == TMO_LAST);
  assign last_byte_s = (byte_cnt_r == LAST_BYTE);
  assign bit_last_s  = (bit_cnt_r == 3'd7);
  assign tx_s        = (state_r == ST_REPLY) && UART_READY;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a timeout terminal count wins over a same-cycle byte.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (IN_VALID) begin
          case (IN_DATA)
            8'h01:   state_nxt_s = ST_LOAD_WAIT;
            8'h03:   state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_REPLY;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD_WAIT: begin
        if (tmo_hit_s) begin
          state_nxt_s = ST_REPLY;
        end else if (IN_VALID) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_LOAD_WAIT;
        end
      end
      ST_SHIFT: begin
        if (bit_last_s) begin
`ifdef CFG_CHAIN_READBACK_EN
          state_nxt_s = ST_REPLY;
`else
          state_nxt_s = last_byte_s ? ST_REPLY : ST_LOAD_WAIT;
`endif
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_REPLY: begin
        if (UART_READY) begin
          state_nxt_s = ret_idle_r ? ST_IDLE : ST_LOAD_WAIT;
        end else begin
          state_nxt_s = ST_REPLY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath: counters, latched byte, reply selection and sticky flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_cnt_r   <= '0;
      bit_cnt_r    <= 3'd0;
      tmo_cnt_r    <= '0;
      load_cnt_r   <= 6'd0;
      ovr_r        <= 1'b0;
      tmo_r        <= 1'b0;
      data_r       <= 8'h00;
      reply_data_r <= 8'h00;
      sel_status_r <= 1'b0;
      ret_idle_r   <= 1'b0;
`ifdef CFG_CHAIN_READBACK_EN
      readback_r   <= 8'h00;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (IN_VALID) begin
            case (IN_DATA)
              8'h01: begin
                byte_cnt_r <= '0;
                tmo_cnt_r  <= '0;
              end
              8'h02: begin
                sel_status_r <= 1'b1;
                ret_idle_r   <= 1'b1;
              end
              8'h03: begin
                ret_idle_r <= ret_idle_r;
              end
              default: begin
                reply_data_r <= 8'hEE;
                sel_status_r <= 1'b0;
                ret_idle_r   <= 1'b1;
              end
            endcase
          end
        end
        ST_LOAD_WAIT: begin
          if (tmo_hit_s) begin
            tmo_r        <= 1'b1;
            reply_data_r <= 8'hE1;
            sel_status_r <= 1'b0;
            ret_idle_r   <= 1'b1;
          end else if (IN_VALID) begin
            data_r    <= IN_DATA;
            tmo_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
          end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end
        ST_SHIFT: begin
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (IN_VALID) begin
            ovr_r <= 1'b1;
          end
`ifdef CFG_CHAIN_READBACK_EN
          readback_r[bit_cnt_r] <= SHIFT_TAIL;
`endif
          if (bit_last_s) begin
            byte_cnt_r   <= byte_cnt_r + BCW'(1);
            sel_status_r <= 1'b0;
            ret_idle_r   <= last_byte_s;
            if (last_byte_s) begin
              load_cnt_r <= load_cnt_r + 6'd1;
            end
`ifdef CFG_CHAIN_READBACK_EN
            reply_data_r <= {SHIFT_TAIL, readback_r[6:0]};
`else
            reply_data_r <= 8'hAC;
`endif
          end
        end
        ST_REPLY: begin
          // A byte dropped in the transmit cycle still leaves OVR set.
          if (IN_VALID) begin
            ovr_r <= 1'b1;
          end else if (UART_READY && sel_status_r) begin
            ovr_r <= 1'b0;
          end
          if (UART_READY && sel_status_r) begin
            tmo_r <= 1'b0;
          end
        end
        default: begin
          bit_cnt_r <= 3'd0;
        end
      endcase
    end
  end

  // Output decode: next-cycle values of the registered outputs.
  always_comb begin
    out_valid_nxt_s    = tx_s;
    out_data_nxt_s     = OUT_DATA;
    shift_enable_nxt_s = (state_nxt_s == ST_SHIFT);
    shift_head_nxt_s   = 1'b0;
    user_step_nxt_s    = (state_r == ST_IDLE) && IN_VALID && (IN_DATA == 8'h03);
    busy_nxt_s         = (state_nxt_s != ST_IDLE);
    if (tx_s) begin
      out_data_nxt_s = sel_status_r ? {ovr_r, tmo_r, load_cnt_r} : reply_data_r;
    end else begin
      out_data_nxt_s = OUT_DATA;
    end
    // Bit 0 comes straight from the byte being latched; later bits from data_r.
    if (state_nxt_s == ST_SHIFT) begin
      shift_head_nxt_s = (state_r == ST_SHIFT) ? data_r[bit_cnt_r + 3'd1] : IN_DATA[0];
    end else begin
      shift_head_nxt_s = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID    <= 1'b0;
      OUT_DATA     <= 8'h00;
      SHIFT_HEAD   <= 1'b0;
      SHIFT_ENABLE <= 1'b0;
      USER_STEP    <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      OUT_VALID    <= out_valid_nxt_s;
      OUT_DATA     <= out_data_nxt_s;
      SHIFT_HEAD   <= shift_head_nxt_s;
      SHIFT_ENABLE <= shift_enable_nxt_s;
      USER_STEP    <= user_step_nxt_s;
      BUSY         <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Directed testbench for cfg_chain_ctrl with a reply scoreboard and a
// 40-bit shift-register model of the configuration chain.
module tb_cfg_chain_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       UART_READY = 1'b1;
  logic       OUT_VALID;
  logic [7:0] OUT_DATA;
  logic       SHIFT_HEAD;
  logic       SHIFT_TAIL;
  logic       SHIFT_ENABLE;
  logic       USER_STEP;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sb_q[$];
  logic [39:0] chain_m = 40'h0;
  logic [39:0] head_log = 40'h0;
  int se_cycles = 0, bursts = 0, bad_runs = 0, run_len = 0;
  int ov_count = 0, us_count = 0;
  int t_cnt, snap;

  cfg_chain_ctrl #(.CHAIN_LEN(40), .TIMEOUT(100)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
    .UART_READY(UART_READY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA),
    .SHIFT_HEAD(SHIFT_HEAD), .SHIFT_TAIL(SHIFT_TAIL),
    .SHIFT_ENABLE(SHIFT_ENABLE), .USER_STEP(USER_STEP), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Chain model: head enters the top, tail leaves bit 0.
  assign SHIFT_TAIL = chain_m[0];
  always @(posedge CLK) begin
    if (SHIFT_ENABLE) chain_m <= {SHIFT_HEAD, chain_m[39:1]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reply scoreboard and shift/step activity monitor.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (OUT_VALID) begin
        ov_count++;
        if (sb_q.size() == 0) begin
          chk("unexpected_reply", {56'h0, OUT_DATA}, 64'h1_0000);
        end else begin
          chk("reply", {56'h0, OUT_DATA}, {56'h0, sb_q.pop_front()});
        end
      end
      if (USER_STEP) us_count++;
      if (SHIFT_ENABLE) begin
        se_cycles++;
        run_len++;
        head_log = {SHIFT_HEAD, head_log[39:1]};
      end else if (run_len != 0) begin
        bursts++;
        if (run_len != 8) bad_runs++;
        run_len = 0;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    IN_DATA  = b;
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) begin
      @(negedge CLK);
      #1;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("rst_out_valid", {63'h0, OUT_VALID}, 64'h0);
    chk("rst_out_data", {56'h0, OUT_DATA}, 64'h0);
    chk("rst_head", {63'h0, SHIFT_HEAD}, 64'h0);
    chk("rst_enable", {63'h0, SHIFT_ENABLE}, 64'h0);
    chk("rst_step", {63'h0, USER_STEP}, 64'h0);
    chk("rst_busy", {63'h0, BUSY}, 64'h0);
    sb_q.delete();
    run_len = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Push the expected reply for a payload byte before it is sent.
  task automatic load_byte(input logic [7:0] b, input bit last);
`ifdef CFG_CHAIN_READBACK_EN
    sb_q.push_back(chain_m[7:0]);
`else
    if (last) sb_q.push_back(8'hAC);
`endif
    send(b);
  endtask

  task automatic load5(input logic [39:0] payload);
    logic [7:0] b;
    send(8'h01);
    for (int i = 0; i < 5; i++) begin
      b = payload[8*i +: 8];
      load_byte(b, i == 4);
      repeat (10) @(negedge CLK);
    end
    drain();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // LOAD 0x11..0x55: five 8-cycle bursts, LSB first.
    se_cycles = 0; bursts = 0; bad_runs = 0;
    send(8'h01);
    chk("busy_after_load_cmd", {63'h0, BUSY}, 64'h1);
    load_byte(8'h11, 1'b0);
    chk("first_shift_cycle", {63'h0, SHIFT_ENABLE}, 64'h1);
    repeat (10) @(negedge CLK);
    load_byte(8'h22, 1'b0); repeat (10) @(negedge CLK);
    load_byte(8'h33, 1'b0); repeat (10) @(negedge CLK);
    load_byte(8'h44, 1'b0); repeat (10) @(negedge CLK);
    load_byte(8'h55, 1'b1); repeat (10) @(negedge CLK);
    drain();
    chk("se_cycles", 64'(se_cycles), 64'd40);
    chk("bursts", 64'(bursts), 64'd5);
    chk("bad_runs", 64'(bad_runs), 64'd0);
    chk("head_bits", {24'h0, head_log}, {24'h0, 40'h5544332211});
    chk("first_burst_head", {56'h0, head_log[7:0]}, 64'h11);
    chk("busy_after_load", {63'h0, BUSY}, 64'h0);

    // Second load: readback returns the first load in order.
    load5(40'hA5A4A3A2A1);
    chk("chain_model", {24'h0, chain_m}, {24'h0, 40'hA5A4A3A2A1});

    // Timeout after one payload byte.
    do_reset();
    send(8'h01);
    load_byte(8'h7F, 1'b0);
    sb_q.push_back(8'hE1);
    t_cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge CLK);
      #1;
      t_cnt = i;
      if (sb_q.size() == 0) break;
    end
    chk("timeout_seen", 64'(sb_q.size()), 64'd0);
    chk("timeout_window", 64'((t_cnt >= 105) && (t_cnt <= 112)), 64'd1);
    sb_q.push_back(8'h40); send(8'h02); drain();
    sb_q.push_back(8'h00); send(8'h02); drain();

    // Overrun: extra byte during SHIFT is dropped.
    do_reset();
    send(8'h01);
    load_byte(8'h01, 1'b0);
    repeat (3) @(negedge CLK);
    send(8'h99);
    repeat (12) @(negedge CLK);
    load_byte(8'h02, 1'b0); repeat (10) @(negedge CLK);
    load_byte(8'h03, 1'b0); repeat (10) @(negedge CLK);
    load_byte(8'h04, 1'b0); repeat (10) @(negedge CLK);
    load_byte(8'h05, 1'b1); repeat (10) @(negedge CLK);
    drain();
    sb_q.push_back(8'h81); send(8'h02); drain();

    // Back-pressure: reply held while UART_READY is low.
    do_reset();
    UART_READY = 1'b0;
    snap = ov_count;
    sb_q.push_back(8'h00);
    send(8'h02);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      chk("hold_out_valid", {63'h0, OUT_VALID}, 64'h0);
      chk("hold_busy", {63'h0, BUSY}, 64'h1);
    end
    UART_READY = 1'b1;
    drain();
    repeat (5) @(negedge CLK);
    chk("one_pulse", 64'(ov_count - snap), 64'd1);
    chk("busy_released", {63'h0, BUSY}, 64'h0);

    // STEP: single pulse, no reply.
    snap = us_count;
    t_cnt = ov_count;
    send(8'h03);
    chk("step_high", {63'h0, USER_STEP}, 64'h1);
    @(negedge CLK);
    chk("step_low", {63'h0, USER_STEP}, 64'h0);
    repeat (5) @(negedge CLK);
    chk("step_count", 64'(us_count - snap), 64'd1);
    chk("step_no_reply", 64'(ov_count - t_cnt), 64'd0);

    // Unknown command.
    sb_q.push_back(8'hEE);
    send(8'h5A);
    drain();
    repeat (3) @(negedge CLK);
    chk("out_data_holds", {56'h0, OUT_DATA}, 64'hEE);

    // Reset in the middle of a shift burst.
    send(8'h01);
    load_byte(8'h0F, 1'b0);
    repeat (2) @(negedge CLK);
    chk("mid_shift_enable", {63'h0, SHIFT_ENABLE}, 64'h1);
    do_reset();
    repeat (3) @(negedge CLK);
    chk("no_shift_after_rst", {63'h0, SHIFT_ENABLE}, 64'h0);
    sb_q.push_back(8'h00); send(8'h02); drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
